pattgen_multi: RTL and testbench

- Parametrised, registered successor to the 8-bar VGA colour-bar generator.
- Takes the current pixel coordinate from the VGA timing block and produces 3-bit RGB.
- Selectable pattern: vertical bars, horizontal bars, checkerboard, or horizontally scrolling bars.
- Sits between the VGA sync/counter block and the RGB output mux. The mode is latched once per frame so patterns never tear mid-frame.

---
 rtl/pattgen_pkg.sv | 20 ++
 rtl/pattgen_bar_lut.sv | 24 ++
 rtl/pattgen_multi.sv | 138 +++++++++++++
 tb/tb_pattgen_multi.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pattgen_pkg.sv
// Shared colour palette and pattern-mode encodings for the pattern generator.
package pattgen_pkg;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] CYAN   = 3'b011;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] PURPLE = 3'b101;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] WHITE  = 3'b111;

    typedef enum logic [1:0] {
        MODE_VBAR   = 2'd0,
        MODE_HBAR   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

endpackage

// File: rtl/pattgen_bar_lut.sv
// Bar index (mod 8) to RGB colour, in the legacy colour-bar order.
module pattgen_bar_lut
    import pattgen_pkg::*;
(
    input  logic [2:0] idx,
    output logic [2:0] rgb
);

    always_comb begin
        rgb = BLACK;
        case (idx)
            3'd0: rgb = BLUE;
            3'd1: rgb = GREEN;
            3'd2: rgb = RED;
            3'd3: rgb = CYAN;
            3'd4: rgb = BLACK;
            3'd5: rgb = YELLOW;
            3'd6: rgb = WHITE;
            3'd7: rgb = PURPLE;
            default: rgb = BLACK;
        endcase
    end

endmodule

// File: rtl/pattgen_multi.sv
// Two-stage registered test-pattern generator: bars, checkerboard, scrolling bars.
// Mode and scroll offset change only at start of frame so a frame never tears.
module pattgen_multi
    import pattgen_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 9,
    parameter int NUM_BARS    = 8,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] colum_i,
    input  logic [1:0]       mode_i,
    output logic [2:0]       rgb_o,
    output logic             valid_o
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BAR_H = V_ACTIVE / NUM_BARS;
    localparam logic [COL_W:0] H_LIM = H_ACTIVE[COL_W:0];
    localparam logic [ROW_W:0] V_LIM = V_ACTIVE[ROW_W:0];
    localparam logic [COL_W:0] STEP  = SCROLL_STEP[COL_W:0];

    logic             en_s1_reg;
    logic [ROW_W-1:0] row_s1_reg;
    logic [COL_W-1:0] col_s1_reg;
    mode_e            mode_reg, mode_next;
    logic [COL_W-1:0] offset_reg, offset_next;
    logic [2:0]       rgb_reg, rgb_next;
    logic             valid_reg;

    logic             sof;
    logic [COL_W:0]   step_sum;
    logic [COL_W:0]   col_sum;
    logic [COL_W-1:0] col_eff;
    logic             in_range;
    logic [NUM_BARS-1:0] col_ge;
    logic [NUM_BARS-1:0] row_ge;
    logic [2:0]       col_idx, row_idx, bar_idx, lut_rgb;

    assign sof = en_i && (row_i == '0) && (colum_i == '0);

    always_comb begin
        mode_next   = mode_reg;
        offset_next = offset_reg;
        step_sum    = {1'b0, offset_reg} + STEP;
        if (sof) begin
            mode_next = mode_e'(mode_i);
            if (mode_reg == MODE_SCROLL && mode_i == MODE_SCROLL) begin
                offset_next = (step_sum >= H_LIM) ? COL_W'(step_sum - H_LIM)
                                                  : COL_W'(step_sum);
            end else begin
                offset_next = '0;
            end
        end
    end

    // Scroll adds an offset below H_ACTIVE to an in-range column, so one subtract wraps it.
    always_comb begin
        col_sum = {1'b0, col_s1_reg};
        if (mode_reg == MODE_SCROLL)
            col_sum = {1'b0, col_s1_reg} + {1'b0, offset_reg};
        col_eff = (col_sum >= H_LIM) ? COL_W'(col_sum - H_LIM) : COL_W'(col_sum);
    end

    // Bar index = number of bar boundaries passed; saturates at NUM_BARS-1 by construction.
    assign col_ge[0] = 1'b0;
    assign row_ge[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_BARS; gi++) begin : g_thr
            localparam int CT = gi * BAR_W;
            localparam int RT = gi * BAR_H;
            localparam logic [COL_W-1:0] COL_THR = CT[COL_W-1:0];
            localparam logic [ROW_W-1:0] ROW_THR = RT[ROW_W-1:0];
            assign col_ge[gi] = (col_eff >= COL_THR);
            assign row_ge[gi] = (row_s1_reg >= ROW_THR);
        end
    endgenerate

    always_comb begin
        col_idx = 3'd0;
        row_idx = 3'd0;
        for (int i = 0; i < NUM_BARS; i++) begin
            col_idx = col_idx + {2'b00, col_ge[i]};
            row_idx = row_idx + {2'b00, row_ge[i]};
        end
    end

    assign bar_idx  = (mode_reg == MODE_HBAR) ? row_idx : col_idx;
    assign in_range = ({1'b0, col_s1_reg} < H_LIM) && ({1'b0, row_s1_reg} < V_LIM);

    pattgen_bar_lut u_lut (
        .idx (bar_idx),
        .rgb (lut_rgb)
    );

    always_comb begin
        rgb_next = BLACK;
        if (en_s1_reg && in_range) begin
            case (mode_reg)
                MODE_VBAR, MODE_SCROLL, MODE_HBAR: rgb_next = lut_rgb;
                MODE_CHECK: rgb_next = (row_s1_reg[CHECK_LOG2] ^ col_s1_reg[CHECK_LOG2])
                                       ? BLACK : WHITE;
                default: rgb_next = BLACK;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en_s1_reg  <= 1'b0;
            row_s1_reg <= '0;
            col_s1_reg <= '0;
            mode_reg   <= MODE_VBAR;
            offset_reg <= '0;
            rgb_reg    <= BLACK;
            valid_reg  <= 1'b0;
        end else begin
            en_s1_reg  <= en_i;
            row_s1_reg <= row_i;
            col_s1_reg <= colum_i;
            mode_reg   <= mode_next;
            offset_reg <= offset_next;
            rgb_reg    <= rgb_next;
            valid_reg  <= en_s1_reg;
        end
    end

    assign rgb_o   = rgb_reg;
    assign valid_o = valid_reg;

endmodule

// File: tb/tb_pattgen_multi.sv
// Directed bench for pattgen_multi: each pixel is driven for one cycle, then checked two edges later.
module tb_pattgen_multi;

    localparam int ROW_W = 9;
    localparam int COL_W = 10;

    logic             clk_i;
    logic             rst_n_i;
    logic             en_i;
    logic [ROW_W-1:0] row_i;
    logic [COL_W-1:0] colum_i;
    logic [1:0]       mode_i;
    logic [2:0]       rgb_o;
    logic             valid_o;

    int checks   = 0;
    int failures = 0;

    // Legacy bar order: BLUE GREEN RED CYAN BLACK YELLOW WHITE PURPLE
    logic [2:0] pal [8] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b110, 3'b111, 3'b101};

    pattgen_multi dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .row_i   (row_i),
        .colum_i (colum_i),
        .mode_i  (mode_i),
        .rgb_o   (rgb_o),
        .valid_o (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={v,rgb}=%b exp=%b", tag, got, exp);
        end else begin
            $display("ok   %s {v,rgb}=%b", tag, got);
        end
    endtask

    task automatic drive(input logic en, input int row, input int col, input logic [1:0] mode);
        en_i    = en;
        row_i   = row[ROW_W-1:0];
        colum_i = col[COL_W-1:0];
        mode_i  = mode;
    endtask

    // One active pixel followed by one blank cycle; result visible after the second edge.
    task automatic pix(input logic en, input int row, input int col, input logic [1:0] mode,
                       input logic exp_v, input logic [2:0] exp_rgb, input string tag);
        drive(en, row, col, mode);
        @(posedge clk_i); #1;
        en_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq(tag, {valid_o, rgb_o}, {exp_v, exp_rgb});
    endtask

    task automatic sof_only(input logic [1:0] mode);
        drive(1'b1, 0, 0, mode);
        @(posedge clk_i); #1;
        en_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        drive(1'b0, 0, 0, 2'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("reset_out", {valid_o, rgb_o}, 4'b0000);
        rst_n_i = 1'b1;

        // Mode 0: vertical bars, 80 px each
        pix(1'b1, 0, 0, 2'd0, 1'b1, 3'b001, "vbar_sof");
        for (int k = 0; k < 8; k++) begin
            pix(1'b1, 10, k*80,    2'd0, 1'b1, pal[k], $sformatf("vbar_c%0d", k*80));
            pix(1'b1, 10, k*80+79, 2'd0, 1'b1, pal[k], $sformatf("vbar_c%0d", k*80+79));
        end

        // Mode 1: horizontal bars, 60 lines each
        pix(1'b1, 0, 0, 2'd1, 1'b1, 3'b001, "hbar_sof");
        for (int k = 0; k < 8; k++) begin
            pix(1'b1, k*60,    5, 2'd1, 1'b1, pal[k], $sformatf("hbar_r%0d", k*60));
            pix(1'b1, k*60+59, 5, 2'd1, 1'b1, pal[k], $sformatf("hbar_r%0d", k*60+59));
        end

        // Mode 2: 32 px checkerboard
        pix(1'b1, 0,  0,  2'd2, 1'b1, 3'b111, "chk_0_0");
        pix(1'b1, 0,  32, 2'd2, 1'b1, 3'b000, "chk_0_32");
        pix(1'b1, 32, 32, 2'd2, 1'b1, 3'b111, "chk_32_32");
        pix(1'b1, 31, 31, 2'd2, 1'b1, 3'b111, "chk_31_31");
        // Blank (0,0) is not a frame start; mid-frame mode change is ignored
        pix(1'b0, 0,  0,  2'd3, 1'b0, 3'b000, "blank_00");
        pix(1'b1, 0,  32, 2'd3, 1'b1, 3'b000, "chk_hold");

        // Mode 3: frame offsets 0, 4, 8
        pix(1'b1, 0, 0,   2'd3, 1'b1, 3'b001, "scr_f1_sof");
        pix(1'b1, 5, 76,  2'd3, 1'b1, 3'b001, "scr_f1_c76");
        pix(1'b1, 0, 0,   2'd3, 1'b1, 3'b001, "scr_f2_sof");
        pix(1'b1, 5, 76,  2'd3, 1'b1, 3'b010, "scr_f2_c76");
        pix(1'b1, 0, 0,   2'd3, 1'b1, 3'b001, "scr_f3_sof");
        pix(1'b1, 5, 632, 2'd3, 1'b1, 3'b001, "scr_f3_c632");
        pix(1'b1, 5, 72,  2'd3, 1'b1, 3'b010, "scr_f3_c72");
        for (int f = 0; f < 157; f++) sof_only(2'd3);
        pix(1'b1, 5, 0,   2'd3, 1'b1, 3'b101, "scr_636_c0");
        pix(1'b1, 5, 3,   2'd3, 1'b1, 3'b101, "scr_636_c3");
        pix(1'b1, 5, 4,   2'd3, 1'b1, 3'b001, "scr_636_c4");
        pix(1'b1, 0, 0,   2'd3, 1'b1, 3'b001, "scr_wrap_sof");
        pix(1'b1, 5, 79,  2'd3, 1'b1, 3'b001, "scr_wrap_c79");
        pix(1'b1, 5, 80,  2'd3, 1'b1, 3'b010, "scr_wrap_c80");
        sof_only(2'd3);
        pix(1'b1, 5, 76,  2'd0, 1'b1, 3'b010, "scr_midsw_c76");
        pix(1'b1, 5, 556, 2'd0, 1'b1, 3'b101, "scr_midsw_c556");
        pix(1'b1, 0, 0,   2'd0, 1'b1, 3'b001, "vbar_back_sof");
        pix(1'b1, 5, 76,  2'd0, 1'b1, 3'b001, "vbar_back_c76");
        pix(1'b1, 5, 80,  2'd0, 1'b1, 3'b010, "vbar_back_c80");
        sof_only(2'd3);
        pix(1'b1, 5, 76,  2'd3, 1'b1, 3'b001, "scr_reentry_c76");
        sof_only(2'd3);
        pix(1'b1, 5, 76,  2'd3, 1'b1, 3'b010, "scr_off4_c76");

        // Blanking and out-of-range coordinates (offset 4, mode 3)
        pix(1'b0, 5,   100, 2'd3, 1'b0, 3'b000, "blank");
        pix(1'b1, 5,   700, 2'd3, 1'b1, 3'b000, "col700");
        pix(1'b1, 500, 10,  2'd3, 1'b1, 3'b000, "row500");
        pix(1'b1, 479, 639, 2'd3, 1'b1, 3'b001, "scr_c639_wrap");

        // Reset mid-line with a pixel in flight
        drive(1'b1, 5, 200, 2'd3);
        @(posedge clk_i); #1;
        drive(1'b1, 5, 300, 2'd3);
        @(posedge clk_i); #1;
        check_eq("pre_rst_red", {valid_o, rgb_o}, 4'b1100);
        rst_n_i = 1'b0;
        en_i    = 1'b0;
        @(posedge clk_i); #1;
        check_eq("rst_edge", {valid_o, rgb_o}, 4'b0000);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check_eq("rst_flushed", {valid_o, rgb_o}, 4'b0000);
        pix(1'b1, 10, 76, 2'd2, 1'b1, 3'b001, "post_rst_mode0_c76");
        pix(1'b1, 10, 80, 2'd2, 1'b1, 3'b010, "post_rst_mode0_c80");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
